mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the IF/MEM memory-port arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grantee_t;

    localparam logic [2:0] DMTYPE_WORD      = 3'b010;
    localparam int         STARVE_LIMIT_DEF = 4;
    localparam int         TIMEOUT_DEF      = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requestor-side (fetch, load/store) and shared memory-port signals of the arbiter.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_dmtype;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [2:0]  bus_dmtype;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    logic        err;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_dmtype,
        input  bus_ready, bus_rdata,
        output if_rdata, if_ack, mem_rdata, mem_ack,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_dmtype, err
    );

    // Requestors plus memory.
    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_dmtype,
        output bus_ready, bus_rdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_dmtype, err
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store onto one memory port; req->bus_req 1 cycle, bus_ready->ack 1 cycle.
// Backpressure: requestors hold req until ack; the bus stalls via bus_ready, aborted after TIMEOUT cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave arb
);

    localparam int CNT_W    = $clog2(TIMEOUT + 1);
    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    state_t               state;
    grantee_t             grantee;
    logic [CNT_W-1:0]     tmo_cnt;
    logic [STREAK_W-1:0]  mem_streak;
    logic                 if_starved;
    logic                 grant_mem;
    logic                 finish;

    // MEM has priority unless IF has already waited out STARVE_LIMIT MEM grants.
    assign if_starved = arb.if_req && (mem_streak == STREAK_MAX);
    assign grant_mem  = arb.mem_req && !if_starved;
    assign finish     = arb.bus_ready || (tmo_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            grantee        <= GNT_IF;
            tmo_cnt        <= '0;
            mem_streak     <= '0;
            arb.bus_req    <= 1'b0;
            arb.bus_we     <= 1'b0;
            arb.bus_addr   <= '0;
            arb.bus_wdata  <= '0;
            arb.bus_dmtype <= '0;
            arb.if_ack     <= 1'b0;
            arb.mem_ack    <= 1'b0;
            arb.err        <= 1'b0;
            arb.if_rdata   <= '0;
            arb.mem_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_mem) begin
                        grantee        <= GNT_MEM;
                        arb.bus_we     <= arb.mem_we;
                        arb.bus_addr   <= arb.mem_addr;
                        arb.bus_wdata  <= arb.mem_wdata;
                        arb.bus_dmtype <= arb.mem_dmtype;
                        if (arb.if_req && (mem_streak != STREAK_MAX)) begin
                            mem_streak <= mem_streak + 1'b1;
                        end
                        tmo_cnt        <= '0;
                        arb.bus_req    <= 1'b1;
                        state          <= ST_BUSY;
                    end else if (arb.if_req) begin
                        grantee        <= GNT_IF;
                        arb.bus_we     <= 1'b0;
                        arb.bus_addr   <= arb.if_addr;
                        arb.bus_wdata  <= '0;
                        arb.bus_dmtype <= DMTYPE_WORD;
                        mem_streak     <= '0;
                        tmo_cnt        <= '0;
                        arb.bus_req    <= 1'b1;
                        state          <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (finish) begin
                        arb.bus_req <= 1'b0;
                        arb.err     <= !arb.bus_ready;
                        state       <= ST_DONE;
                        // An aborted access returns zero data, stores included.
                        if (grantee == GNT_IF) begin
                            arb.if_ack   <= 1'b1;
                            arb.if_rdata <= arb.bus_ready ? arb.bus_rdata : '0;
                        end else begin
                            arb.mem_ack <= 1'b1;
                            if (!arb.bus_ready) begin
                                arb.mem_rdata <= '0;
                            end else if (!arb.bus_we) begin
                                arb.mem_rdata <= arb.bus_rdata;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    arb.if_ack  <= 1'b0;
                    arb.mem_ack <= 1'b0;
                    arb.err     <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, starvation, store, timeout, reset abort.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if arb();

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (arb.bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got %b want 0", arb.bus_req); end
        checks++; if ({arb.if_ack, arb.mem_ack, arb.err} !== 3'b000) begin errors++; $display("FAIL rst_acks got %b want 000", {arb.if_ack, arb.mem_ack, arb.err}); end
        checks++; if (arb.if_rdata !== 32'h0 || arb.mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h want 0/0", arb.if_rdata, arb.mem_rdata); end
        checks++; if ({arb.bus_we, arb.bus_addr, arb.bus_wdata, arb.bus_dmtype} !== 68'h0) begin errors++; $display("FAIL rst_bus_fields got %h want 0", {arb.bus_we, arb.bus_addr, arb.bus_wdata, arb.bus_dmtype}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        arb.if_req  = 1'b1;
        arb.if_addr = 32'h0000_0004;
        tick();
        checks++; if (arb.bus_req !== 1'b1 || arb.bus_addr !== 32'h4) begin errors++; $display("FAIL fetch_bus got req=%b addr=%h want 1/00000004", arb.bus_req, arb.bus_addr); end
        checks++; if (arb.bus_we !== 1'b0 || arb.bus_dmtype !== 3'b010 || arb.bus_wdata !== 32'h0) begin errors++; $display("FAIL fetch_fields got we=%b dm=%b wd=%h want 0/010/0", arb.bus_we, arb.bus_dmtype, arb.bus_wdata); end
        tick();
        checks++; if (arb.if_ack !== 1'b0) begin errors++; $display("FAIL fetch_early_ack got %b want 0", arb.if_ack); end
        tick();
        arb.bus_ready = 1'b1;
        arb.bus_rdata = 32'h0010_0093;
        tick();
        arb.bus_ready = 1'b0;
        checks++; if (arb.if_ack !== 1'b1 || arb.mem_ack !== 1'b0 || arb.err !== 1'b0) begin errors++; $display("FAIL fetch_ack got if=%b mem=%b err=%b want 1/0/0", arb.if_ack, arb.mem_ack, arb.err); end
        checks++; if (arb.if_rdata !== 32'h0010_0093) begin errors++; $display("FAIL fetch_rdata got %h want 00100093", arb.if_rdata); end
        checks++; if (arb.bus_req !== 1'b0) begin errors++; $display("FAIL fetch_done_bus_req got %b want 0", arb.bus_req); end
        tick();
        arb.if_req = 1'b0;
        checks++; if (arb.if_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack_pulse got %b want 0", arb.if_ack); end
        tick();
    endtask

    task automatic test_both();
        arb.if_req     = 1'b1;
        arb.if_addr    = 32'h0000_0008;
        arb.mem_req    = 1'b1;
        arb.mem_we     = 1'b0;
        arb.mem_addr   = 32'h0000_0100;
        arb.mem_wdata  = 32'h0000_0005;
        arb.mem_dmtype = 3'b010;
        tick();
        checks++; if (arb.bus_req !== 1'b1 || arb.bus_addr !== 32'h100 || arb.bus_wdata !== 32'h5) begin errors++; $display("FAIL both_mem_first got req=%b addr=%h wd=%h want 1/00000100/00000005", arb.bus_req, arb.bus_addr, arb.bus_wdata); end
        arb.bus_ready = 1'b1;
        arb.bus_rdata = 32'hAAAA_5555;
        tick();
        arb.bus_ready = 1'b0;
        checks++; if (arb.mem_ack !== 1'b1 || arb.if_ack !== 1'b0) begin errors++; $display("FAIL both_mem_ack got mem=%b if=%b want 1/0", arb.mem_ack, arb.if_ack); end
        checks++; if (arb.mem_rdata !== 32'hAAAA_5555) begin errors++; $display("FAIL both_mem_rdata got %h want aaaa5555", arb.mem_rdata); end
        tick();
        arb.mem_req = 1'b0;
        checks++; if (arb.mem_ack !== 1'b0 || arb.if_ack !== 1'b0) begin errors++; $display("FAIL both_gap got mem=%b if=%b want 0/0", arb.mem_ack, arb.if_ack); end
        tick();
        checks++; if (arb.bus_addr !== 32'h8 || arb.bus_dmtype !== 3'b010 || arb.bus_wdata !== 32'h0) begin errors++; $display("FAIL both_if_grant got addr=%h dm=%b wd=%h want 00000008/010/0", arb.bus_addr, arb.bus_dmtype, arb.bus_wdata); end
        arb.bus_ready = 1'b1;
        arb.bus_rdata = 32'h1111_2222;
        tick();
        arb.bus_ready = 1'b0;
        checks++; if (arb.if_ack !== 1'b1 || arb.mem_ack !== 1'b0 || arb.if_rdata !== 32'h1111_2222) begin errors++; $display("FAIL both_if_ack got if=%b mem=%b rd=%h want 1/0/11112222", arb.if_ack, arb.mem_ack, arb.if_rdata); end
        tick();
        arb.if_req = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        logic [31:0] want_addr;
        arb.if_req   = 1'b1;
        arb.if_addr  = 32'h0000_0040;
        arb.mem_req  = 1'b1;
        arb.mem_we   = 1'b0;
        arb.mem_addr = 32'h0000_0300;
        for (int i = 0; i < 5; i++) begin
            want_addr = (i < 4) ? 32'h300 : 32'h40;
            tick();
            checks++; if (arb.bus_req !== 1'b1 || arb.bus_addr !== want_addr) begin errors++; $display("FAIL starve_grant%0d got req=%b addr=%h want 1/%h", i, arb.bus_req, arb.bus_addr, want_addr); end
            arb.bus_ready = 1'b1;
            arb.bus_rdata = 32'h1111_2222;
            tick();
            arb.bus_ready = 1'b0;
            checks++; if ({arb.if_ack, arb.mem_ack} !== ((i < 4) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL starve_ack%0d got if=%b mem=%b", i, arb.if_ack, arb.mem_ack); end
            tick();
            if (i == 4) begin
                arb.if_req  = 1'b0;
                arb.mem_req = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_store();
        arb.mem_req  = 1'b1;
        arb.mem_we   = 1'b0;
        arb.mem_addr = 32'h0000_0204;
        tick();
        arb.bus_ready = 1'b1;
        arb.bus_rdata = 32'h0000_1234;
        tick();
        arb.bus_ready = 1'b0;
        checks++; if (arb.mem_rdata !== 32'h0000_1234) begin errors++; $display("FAIL store_preload got %h want 00001234", arb.mem_rdata); end
        tick();
        arb.mem_req = 1'b0;
        tick();
        arb.mem_req    = 1'b1;
        arb.mem_we     = 1'b1;
        arb.mem_addr   = 32'h0000_0200;
        arb.mem_wdata  = 32'hDEAD_BEEF;
        arb.mem_dmtype = 3'b010;
        arb.bus_rdata  = 32'hFFFF_FFFF;
        tick();
        checks++; if (arb.bus_we !== 1'b1 || arb.bus_wdata !== 32'hDEAD_BEEF || arb.bus_addr !== 32'h200) begin errors++; $display("FAIL store_bus got we=%b wd=%h addr=%h want 1/deadbeef/00000200", arb.bus_we, arb.bus_wdata, arb.bus_addr); end
        arb.bus_ready = 1'b1;
        tick();
        arb.bus_ready = 1'b0;
        checks++; if (arb.mem_ack !== 1'b1 || arb.err !== 1'b0) begin errors++; $display("FAIL store_ack got ack=%b err=%b want 1/0", arb.mem_ack, arb.err); end
        checks++; if (arb.mem_rdata !== 32'h0000_1234) begin errors++; $display("FAIL store_rdata_kept got %h want 00001234", arb.mem_rdata); end
        tick();
        arb.mem_req = 1'b0;
        arb.mem_we  = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        arb.if_req    = 1'b1;
        arb.if_addr   = 32'h0000_0080;
        arb.bus_ready = 1'b0;
        tick();
        n = 0;
        while (arb.bus_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL timeout_busy_cycles got %0d want 8", n); end
        checks++; if (arb.if_ack !== 1'b1 || arb.err !== 1'b1) begin errors++; $display("FAIL timeout_ack got ack=%b err=%b want 1/1", arb.if_ack, arb.err); end
        checks++; if (arb.if_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rdata got %h want 0", arb.if_rdata); end
        tick();
        arb.if_req = 1'b0;
        checks++; if (arb.err !== 1'b0 || arb.if_ack !== 1'b0 || arb.bus_req !== 1'b0) begin errors++; $display("FAIL timeout_idle got err=%b ack=%b req=%b want 0/0/0", arb.err, arb.if_ack, arb.bus_req); end
        tick();
    endtask

    task automatic test_reset_busy();
        arb.if_req   = 1'b1;
        arb.if_addr  = 32'h0000_0010;
        arb.mem_req  = 1'b1;
        arb.mem_we   = 1'b0;
        arb.mem_addr = 32'h0000_0300;
        tick();
        // A cleared streak lets MEM win again after the starvation episode.
        checks++; if (arb.bus_req !== 1'b1 || arb.bus_addr !== 32'h300) begin errors++; $display("FAIL streak_cleared got req=%b addr=%h want 1/00000300", arb.bus_req, arb.bus_addr); end
        reset        = 1'b0;
        arb.if_req   = 1'b0;
        arb.mem_req  = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (arb.bus_req !== 1'b0 || {arb.if_ack, arb.mem_ack, arb.err} !== 3'b000) begin errors++; $display("FAIL rstbusy_abort got req=%b acks=%b want 0/000", arb.bus_req, {arb.if_ack, arb.mem_ack, arb.err}); end
        arb.bus_ready = 1'b1;
        tick();
        tick();
        arb.bus_ready = 1'b0;
        checks++; if (arb.bus_req !== 1'b0 || {arb.if_ack, arb.mem_ack, arb.err} !== 3'b000) begin errors++; $display("FAIL rstbusy_quiet got req=%b acks=%b want 0/000", arb.bus_req, {arb.if_ack, arb.mem_ack, arb.err}); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b0;
        arb.if_req     = 1'b0;
        arb.if_addr    = '0;
        arb.mem_req    = 1'b0;
        arb.mem_we     = 1'b0;
        arb.mem_addr   = '0;
        arb.mem_wdata  = '0;
        arb.mem_dmtype = '0;
        arb.bus_ready  = 1'b0;
        arb.bus_rdata  = '0;
        #1;
        test_reset();
        test_fetch();
        test_both();
        test_starve();
        test_store();
        test_timeout();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
